// File: rtl/xor_pack_pkg.sv
// Shared types and helpers for the XOR stream packer.
// Holds the FSM state type, the count-width helper and the legal width range.

package xor_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } xor_pack_state_e;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 64;

    function automatic int cnt_width(int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/xor_stream_packer.sv
// Packs the 1-bit registered XOR stream into WIDTH-bit words on a valid/ready sink interface.
// Optional feature macro XOR_PACK_PARITY_EN adds a registered word_parity output.

module xor_stream_packer
    import xor_pack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         bit_in,
    input  logic                         bit_valid,
    output logic                         bit_ready,
    input  logic                         flush,
    output logic [WIDTH-1:0]             word_out,
    output logic [cnt_width(WIDTH)-1:0]  word_count,
    output logic                         word_valid,
    input  logic                         word_ready
`ifdef XOR_PACK_PARITY_EN
    ,
    output logic                         word_parity
`endif
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   FULL_CNT = CW'(WIDTH);
    localparam logic [WIDTH-1:0] LOW_BIT = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TOP_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("xor_stream_packer: WIDTH out of range");
    end

    xor_pack_state_e  state;
    xor_pack_state_e  state_next;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;
    logic             flush_pend;

    logic             accept;
    logic             handoff;
    logic             emit;
    logic             flush_req;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] shift_fill;
    logic [CW-1:0]    cnt_fill;

    assign word_valid = (state == HOLD);

    // The output register is free whenever it is empty or being handed off this
    // cycle, which is exactly when a new bit may enter; so bit_ready doubles as
    // the "may load a word" condition. shift_fill/cnt_fill already include the
    // bit accepted this cycle, so a flush or completion sees it.
    always_comb begin
        bit_ready  = (state == FILL) || word_ready;
        accept     = bit_valid && bit_ready;
        handoff    = (state == HOLD) && word_ready;
        bit_mask   = MSB_FIRST ? (TOP_BIT >> cnt) : (LOW_BIT << cnt);
        shift_fill = (accept && bit_in) ? (shift_reg | bit_mask) : shift_reg;
        cnt_fill   = cnt + CW'(accept);
        flush_req  = flush || flush_pend;
        emit       = bit_ready &&
                     ((cnt_fill == FULL_CNT) || (flush_req && (cnt_fill != '0)));
        state_next = state;
        if (emit) begin
            state_next = HOLD;
        end else if (handoff) begin
            state_next = FILL;
        end
    end

    // A flush that arrives while a word is stuck in HOLD is parked in flush_pend
    // and resolved on the first cycle the output register frees up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            shift_reg   <= '0;
            cnt         <= '0;
            flush_pend  <= 1'b0;
            word_out    <= '0;
            word_count  <= '0;
`ifdef XOR_PACK_PARITY_EN
            word_parity <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (emit) begin
                word_out    <= shift_fill;
                word_count  <= cnt_fill;
`ifdef XOR_PACK_PARITY_EN
                word_parity <= ^shift_fill;
`endif
                shift_reg   <= '0;
                cnt         <= '0;
            end else begin
                shift_reg   <= shift_fill;
                cnt         <= cnt_fill;
            end
            if (bit_ready) begin
                flush_pend <= 1'b0;
            end else if (flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

endmodule
